// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter for the register file write port, with a
//            destination-register scoreboard for RAW/WAW stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ready,
  input  logic [AW-1:0]   AddrS,
  input  logic [AW-1:0]   AddrT,
  output logic            busy_s,
  output logic            busy_t,
  output logic [NREG-1:0] busy,
  output logic            WrRegEn,
  output logic [AW-1:0]   WrSel,
  output logic [DW-1:0]   DataIn
);

  logic            r_rrPtr;
  logic            r_wrRegEn;
  logic [AW-1:0]   r_wrSel;
  logic [DW-1:0]   r_dataIn;
  logic [NREG-1:0] r_busy;

  logic            w_grant0;
  logic            w_grant1;
  logic [NREG-1:0] w_setMask;
  logic [NREG-1:0] w_clrMask;
  logic [NREG-1:0] w_busyNext;

  // rr_ptr only matters when both requesters contend.
  assign w_grant0 = req0_valid & (~req1_valid | ~r_rrPtr);
  assign w_grant1 = req1_valid & (~req0_valid |  r_rrPtr);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsv_ready  = ~r_busy[rsv_addr];

  // Clear lands on the same edge the register file commits; set wins on a tie.
  always_comb begin
    w_setMask  = '0;
    w_clrMask  = '0;
    if (rsv_en && rsv_ready) w_setMask = NREG'(1) << rsv_addr;
    if (r_wrRegEn)           w_clrMask = NREG'(1) << r_wrSel;
    w_busyNext = (r_busy & ~w_clrMask) | w_setMask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrPtr   <= 1'b0;
      r_wrRegEn <= 1'b0;
      r_wrSel   <= '0;
      r_dataIn  <= '0;
      r_busy    <= '0;
    end else begin
      r_wrRegEn <= w_grant0 | w_grant1;
      r_busy    <= w_busyNext;
      if (w_grant0) begin
        r_rrPtr  <= 1'b1;
        r_wrSel  <= req0_addr;
        r_dataIn <= req0_data;
      end else if (w_grant1) begin
        r_rrPtr  <= 1'b0;
        r_wrSel  <= req1_addr;
        r_dataIn <= req1_data;
      end
    end
  end

  assign WrRegEn = r_wrRegEn;
  assign WrSel   = r_wrSel;
  assign DataIn  = r_dataIn;
  assign busy    = r_busy;
  assign busy_s  = r_busy[AddrS];
  assign busy_t  = r_busy[AddrT];

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the 8x16 register file's single write port between two writeback requesters: req0 (ALU) and req1 (load unit).
- Keeps a per-register scoreboard of outstanding destination reservations so that issue logic can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file. It drives the register file's WrRegEn, WrSel and DataIn through registered outputs.

Parameters:
- NREG, 8, number of architectural registers. Fixed at 8; sizes the scoreboard.
- AW, 3, register address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  AW  ALU destination register.
- req0_data  in  DW  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_addr  in  AW  load destination register.
- req1_data  in  DW  load data.
- req1_ready  out  1  load request accepted this cycle.
- rsv_en  in  1  issue stage reserves a destination register.
- rsv_addr  in  AW  register being reserved.
- rsv_ready  out  1  reservation accepted this cycle.
- AddrS  in  AW  source register S being read by issue.
- AddrT  in  AW  source register T being read by issue.
- busy_s  out  1  busy[AddrS].
- busy_t  out  1  busy[AddrT].
- busy  out  NREG  scoreboard vector.
- WrRegEn  out  1  register file write enable (registered).
- WrSel  out  AW  register file write address (registered).
- DataIn  out  DW  register file write data (registered).

Behaviour:
- Reset (async, rst=1): WrRegEn=0, WrSel=0, DataIn=0, busy=8'h00, rr_ptr=0 (req0 favoured).
  - Outstanding requests are dropped. Requesters must re-present them after reset.
- Arbitration is combinational within the cycle:
  - Only reqX_valid=1: grant X.
  - Both valid: grant req0 if rr_ptr=0, else req1.
  - reqX_ready = grant to X. At most one ready per cycle.
  - No grant when neither request is valid.
- Transfer occurs when reqX_valid & reqX_ready. The requester must hold addr/data stable while valid and not ready.
- Round-robin pointer: on a transfer from X, rr_ptr <= ~X at the clock edge. No transfer: rr_ptr holds.
- Write pipeline, latency 1:
  - A transfer in cycle N drives WrRegEn=1 with WrSel/DataIn equal to the granted addr/data during cycle N+1.
  - The register file writes at the end of N+1.
  - No transfer in N: WrRegEn=0 in N+1, and WrSel/DataIn hold their previous values.
  - Back-to-back transfers give WrRegEn=1 on consecutive cycles. Throughput is one write per cycle.
- Scoreboard:
  - rsv_ready = ~busy[rsv_addr] (WAW stall).
  - rsv_en & rsv_ready sets busy[rsv_addr] at the clock edge.
  - The clear for busy[WrSel] happens at the edge that ends a cycle with WrRegEn=1, which is the same edge the register file writes. The register therefore reads non-busy only once the new value is visible.
  - A write to a register that was never reserved is legal. Its clear has no effect.
  - Simultaneous set and clear of the same register: set wins, busy=1.
  - Set and clear of different registers in the same cycle: both take effect.
- busy_s = busy[AddrS] and busy_t = busy[AddrT], both combinational from the current scoreboard. Register 0 has no special treatment.
- Requesters are not checked against the scoreboard. Any valid request is arbitrated.

Test Plan:
- Reset: assert rst mid-cycle with busy=8'h24 and WrRegEn=1 -> all outputs 0 and busy=0 immediately (asynchronously); rr_ptr=0.
- Single requester: req0 {addr=3, data=16'hBEEF} valid in cycle 1 -> req0_ready=1 in cycle 1; cycle 2 shows WrRegEn=1, WrSel=3, DataIn=16'hBEEF; cycle 3 shows WrRegEn=0.
- Contention: both requests valid for 4 cycles (req0 addr 1 / data 16'h0011, req1 addr 2 / data 16'h0022, each dropping valid after acceptance) -> grants req0 then req1; after re-presenting both, grants req0, req1 again (alternating); WrRegEn high for 4 consecutive cycles.
- Hazard timing: reserve r5 (busy_s=1 with AddrS=5); req1 writes r5 in cycle N -> WrRegEn in N+1; busy_s stays 1 through N+1 and is 0 from N+2.
- WAW stall: reserve r6, then rsv_en with rsv_addr=6 -> rsv_ready=0 and busy unchanged; after the r6 write commits, rsv_ready=1.
- Collision: rsv_en for r4 in the same cycle as an unreserved write commit to r4 (WrRegEn=1, WrSel=4) -> busy[4]=1 next cycle.
